text_console: RTL and testbench

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/text_console.sv | 162 ++++++++++++++++
 tb/tb_text_console.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// rtl/text_console.sv - character console writer: prints bytes into a cell VRAM with scroll and clear
module text_console #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_style,
  output logic [15:0] vram_addr,
  output logic [15:0] vram_wdata,
  output logic        vram_we,
  output logic        vram_re,
  input  logic [15:0] vram_rdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, EXEC, SCROLL_RD, SCROLL_WR, BLANK, CLEAR} state_t;

  localparam logic [15:0] COLS_W      = 16'(COLS);
  localparam logic [15:0] COPY_LAST   = 16'((ROWS - 1) * COLS - 1);
  localparam logic [15:0] BLANK_FIRST = 16'((ROWS - 1) * COLS);
  localparam logic [15:0] CELL_LAST   = 16'(ROWS * COLS - 1);
  localparam logic [6:0]  X_LAST      = 7'(COLS - 1);
  localparam logic [4:0]  Y_LAST      = 5'(ROWS - 1);

  state_t      state;
  state_t      exec_next;
  logic [7:0]  char_q;
  logic [7:0]  style_q;
  logic [15:0] idx;
  logic [15:0] cell_addr;
  logic [6:0]  next_x;
  logic [4:0]  next_y;
  logic        advance;
  logic        is_print;
  logic        is_bs;

  assign is_print  = (char_q >= 8'h20) && (char_q != 8'h7F);
  assign is_bs     = (char_q == 8'h08) && (cursor_x != 7'd0);
  assign cell_addr = 16'(cursor_y) * COLS_W + 16'(cursor_x);
  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;

  // Cursor motion and follow-on state for the latched byte, used on the EXEC edge.
  always_comb begin
    next_x    = cursor_x;
    next_y    = cursor_y;
    advance   = 1'b0;
    exec_next = IDLE;
    if (is_print) begin
      if (cursor_x == X_LAST) begin
        next_x  = 7'd0;
        advance = 1'b1;
      end else begin
        next_x = cursor_x + 7'd1;
      end
    end else begin
      case (char_q)
        8'h0A: begin
          next_x  = 7'd0;
          advance = 1'b1;
        end
        8'h0D: next_x = 7'd0;
        8'h08: if (cursor_x != 7'd0) next_x = cursor_x - 7'd1;
        8'h0C: begin
          next_x    = 7'd0;
          next_y    = 5'd0;
          exec_next = CLEAR;
        end
        default: ;
      endcase
    end
    if (advance) begin
      if (cursor_y == Y_LAST) exec_next = SCROLL_RD;
      else                    next_y    = cursor_y + 5'd1;
    end
  end

  // Strobes decode from state only, so an async reset drops them immediately.
  always_comb begin
    vram_we    = 1'b0;
    vram_re    = 1'b0;
    vram_addr  = 16'd0;
    vram_wdata = 16'd0;
    case (state)
      EXEC: begin
        if (is_print) begin
          vram_we    = 1'b1;
          vram_addr  = cell_addr;
          vram_wdata = {style_q, char_q};
        end else if (is_bs) begin
          vram_we    = 1'b1;
          vram_addr  = cell_addr - 16'd1;
          vram_wdata = {style_q, 8'h20};
        end
      end
      SCROLL_RD: begin
        vram_re   = 1'b1;
        vram_addr = idx + COLS_W;
      end
      SCROLL_WR: begin
        vram_we    = 1'b1;
        vram_addr  = idx;
        vram_wdata = vram_rdata;
      end
      BLANK, CLEAR: begin
        vram_we    = 1'b1;
        vram_addr  = idx;
        vram_wdata = {style_q, 8'h20};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cursor_x <= 7'd0;
      cursor_y <= 5'd0;
      char_q   <= 8'd0;
      style_q  <= 8'd0;
      idx      <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            char_q  <= in_data;
            style_q <= in_style;
            state   <= EXEC;
          end
        end
        EXEC: begin
          cursor_x <= next_x;
          cursor_y <= next_y;
          idx      <= 16'd0;
          state    <= exec_next;
        end
        SCROLL_RD: state <= SCROLL_WR;
        SCROLL_WR: begin
          if (idx == COPY_LAST) begin
            idx   <= BLANK_FIRST;
            state <= BLANK;
          end else begin
            idx   <= idx + 16'd1;
            state <= SCROLL_RD;
          end
        end
        BLANK, CLEAR: begin
          if (idx == CELL_LAST) state <= IDLE;
          else                  idx   <= idx + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// tb/tb_text_console.sv - scoreboard bench for text_console with a behavioural VRAM
module tb_text_console;

  localparam int C = 80;
  localparam int R = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic [7:0]  in_style = 8'd0;
  logic [15:0] vram_addr;
  logic [15:0] vram_wdata;
  logic        vram_we;
  logic        vram_re;
  logic [15:0] vram_rdata = 16'd0;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  logic [31:0] wq[$];
  logic [15:0] rq[$];
  logic [15:0] mem [0:65535];
  logic [15:0] exp_mem [0:R*C-1];
  bit          init_done;
  int          mx = 0;
  int          my = 0;

  text_console #(.COLS(C), .ROWS(R)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_style(in_style), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re),
    .vram_rdata(vram_rdata), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= (i < R*C) ? 16'(i * 7 + 3) : 16'd0;
      init_done <= 1'b1;
    end else begin
      if (vram_we) mem[vram_addr] <= vram_wdata;
      if (vram_re) vram_rdata <= mem[vram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every strobe pops the matching scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vram_we && vram_re) chk("we_re_overlap", 1, 0);
      if (vram_re) begin
        rd_cnt++;
        if (rq.size() == 0) chk("unexpected_read", {16'd0, vram_addr}, 32'hFFFF_FFFF);
        else chk("read_addr", {16'd0, vram_addr}, {16'd0, rq.pop_front()});
      end
      if (vram_we) begin
        if (wq.size() == 0) chk("unexpected_write", {vram_addr, vram_wdata}, 32'hFFFF_FFFF);
        else chk("write_addr_data", {vram_addr, vram_wdata}, wq.pop_front());
      end
    end
  end

  task automatic push_wr(input int a, input logic [15:0] d);
    wq.push_back({16'(a), d});
    exp_mem[a] = d;
  endtask

  task automatic model_byte(input logic [7:0] d, input logic [7:0] s);
    bit adv = 0;
    if (d >= 8'h20 && d != 8'h7F) begin
      push_wr(my*C + mx, {s, d});
      if (mx == C-1) begin mx = 0; adv = 1; end
      else mx++;
    end else if (d == 8'h0A) begin
      mx = 0; adv = 1;
    end else if (d == 8'h0D) begin
      mx = 0;
    end else if (d == 8'h08) begin
      if (mx > 0) begin mx--; push_wr(my*C + mx, {s, 8'h20}); end
    end else if (d == 8'h0C) begin
      for (int i = 0; i < R*C; i++) push_wr(i, {s, 8'h20});
      mx = 0; my = 0;
    end
    if (adv) begin
      if (my == R-1) begin
        for (int i = 0; i < (R-1)*C; i++) begin
          rq.push_back(16'(i + C));
          push_wr(i, exp_mem[i + C]);
        end
        for (int i = (R-1)*C; i < R*C; i++) push_wr(i, {s, 8'h20});
      end else my++;
    end
  endtask

  task automatic accept(input logic [7:0] d, input logic [7:0] s);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    in_valid = 1'b1; in_data = d; in_style = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = 8'h0C; in_style = 8'hFF;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] s, input int exp_busy);
    int n = 0;
    model_byte(d, s);
    accept(d, s);
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 20000) break;
    end
    chk($sformatf("busy_cycles_%h", d), n, exp_busy);
    chk("scoreboard_drained", wq.size() + rq.size(), 0);
  endtask

  task automatic chk_cursor(input string name, input int x, input int y);
    chk(name, {cursor_y, cursor_x}, {5'(y), 7'(x)});
  endtask

  initial begin
    int n;
    int base;
    for (int i = 0; i < R*C; i++) exp_mem[i] = 16'(i * 7 + 3);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {vram_we, vram_re}, 0);
    chk("rst_addr_wdata", {vram_addr, vram_wdata}, 0);
    chk_cursor("rst_cursor", 0, 0);
    rst_n = 1'b1;

    send(8'h41, 8'h07, 1);
    chk_cursor("cursor_after_A", 1, 0);
    send(8'h0D, 8'h07, 1);
    for (int k = 0; k < C; k++) send(8'h30 + 8'(k % 10), 8'h12, 1);
    chk_cursor("cursor_after_row", 0, 1);

    send(8'h0A, 8'h07, 1);
    send(8'h0A, 8'h07, 1);
    for (int k = 0; k < 5; k++) send(8'h61, 8'h07, 1);
    chk_cursor("cursor_5_3", 5, 3);
    chk("bs_expected_word", wq.size(), 0);
    send(8'h08, 8'h1F, 1);
    chk_cursor("cursor_after_bs", 4, 3);
    chk("bs_cell_244", exp_mem[244], 16'h1F20);
    send(8'h0D, 8'h07, 1);
    send(8'h08, 8'h1F, 1);
    chk_cursor("cursor_bs_at_0", 0, 3);

    for (int k = 0; k < 26; k++) send(8'h0A, 8'h07, 1);
    for (int k = 0; k < 10; k++) send(8'h62, 8'h07, 1);
    chk_cursor("cursor_10_29", 10, 29);
    send(8'h0A, 8'h07, 4721);
    chk_cursor("cursor_after_scroll", 0, 29);
    chk("mem_2399_blank", mem[2399], 16'h0720);

    send(8'h0C, 8'h38, 2401);
    chk_cursor("cursor_after_clear", 0, 0);
    chk("mem_1234_clear", mem[1234], 16'h3820);

    for (int k = 0; k < 29; k++) send(8'h0A, 8'h07, 1);
    model_byte(8'h0A, 8'h07);
    accept(8'h0A, 8'h07);
    base = rd_cnt;
    n = 0;
    while (rd_cnt < base + 1000 && n < 5000) begin @(posedge clk); n++; end
    chk("scroll_reached_word_1000", n < 5000, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_drop_strobes", {vram_we, vram_re}, 0);
    chk("async_in_ready", in_ready, 1);
    wq.delete();
    rq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_busy", busy, 0);
    chk_cursor("post_reset_cursor", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
